// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with HI/LO registers (optional MDU_EARLY_TERM_EN shortens MUL)
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_operation,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);
  localparam int N = DATA_WIDTH;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d, mc_q, mc_d, prod;
  logic [N-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag, quo, rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, dz_q, dz_d, done_q, done_d;
  logic a_neg, b_neg, last, mul_end;
  logic [N:0] diff;
  assign a_neg = ~i_operation[0] & i_data_a[N-1];
  assign b_neg = ~i_operation[0] & i_data_b[N-1];
  assign a_mag = a_neg ? -i_data_a : i_data_a;
  assign b_mag = b_neg ? -i_data_b : i_data_b;
  assign last = cnt_q == CW'(N - 1);
`ifdef MDU_EARLY_TERM_EN
  assign mul_end = last || m_q[N-1:1] == '0;
`else
  assign mul_end = last;
`endif
  // restoring-division trial subtract of the shifted partial remainder
  assign diff = acc_q[2*N-1:N-1] - {1'b0, mc_q[N-1:0]};
  assign prod = neg_q ? -acc_q : acc_q;
  assign quo = dz_q ? '1 : (neg_q ? -acc_q[N-1:0] : acc_q[N-1:0]);
  assign rem = rneg_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
  assign o_busy = state_q != IDLE;
  assign o_done = done_q;
  assign o_hi = hi_q;
  assign o_lo = lo_q;
  // next-state and datapath: accept/MTHI/MTLO in IDLE, one bit per cycle in MUL/DIV, sign fix and commit in FIX
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    mc_d = mc_q;
    m_d = m_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    div_d = div_q;
    dz_d = dz_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        if (i_operation < 3'd4) begin
          state_d = i_operation[1] ? DIV : MUL;
          acc_d = i_operation[1] ? {{N{1'b0}}, a_mag} : '0;
          mc_d = {{N{1'b0}}, i_operation[1] ? b_mag : a_mag};
          m_d = b_mag;
          cnt_d = '0;
          neg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          div_d = i_operation[1];
          dz_d = i_data_b == '0;
        end else if (i_operation == 3'd4) hi_d = i_data_a;
        else if (i_operation == 3'd5) lo_d = i_data_a;
      end
      MUL: begin
        acc_d = acc_q + (m_q[0] ? mc_q : '0);
        mc_d = mc_q << 1;
        m_d = m_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (mul_end) state_d = FIX;
      end
      DIV: begin
        acc_d = diff[N] ? {acc_q[2*N-2:0], 1'b0} : {diff[N-1:0], acc_q[N-2:0], 1'b1};
        cnt_d = cnt_q + CW'(1);
        if (last) state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = div_q ? {rem, quo} : prod;
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  // state and datapath registers; async reset aborts any operation in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      mc_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      div_q <= 1'b0;
      dz_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      mc_q <= mc_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      div_q <= div_d;
      dz_q <= dz_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
endmodule
